// File: rtl/pwm_mc.sv
// Multi-channel PWM generator with one shared counter and edge- or center-aligned periods.
// Duty values are double-buffered so that new duties take effect only at period boundaries.
module pwm_mc #(
    parameter int CH = 2,
    parameter int W  = 8
) (
    input  logic            clk,
    input  logic            resetb,
    input  logic            ena,
    input  logic            center_mode,
    input  logic [CH-1:0]   polarity,
    input  logic [CH*W-1:0] duty_in,
    input  logic            duty_load,
    output logic            pending,
    output logic            period_start,
    output logic [CH-1:0]   pwm_out
);

    localparam logic [W-1:0] MAX = {W{1'b1}};

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;
    logic         dir_down;
    logic         dir_nxt;
    logic         mode_act;
    logic         apply;
    logic [W-1:0] duty_stg [CH];
    logic [W-1:0] duty_act [CH];
    logic [W-1:0] duty_eff [CH];
    logic [CH-1:0] raw;

    assign apply = ena && (cnt == '0) && !dir_down;

    // Center mode turns around at MAX and at 1, so both ends of the triangle are visited once.
    always_comb begin
        cnt_nxt = '0;
        dir_nxt = 1'b0;
        if (ena) begin
            if (!mode_act) begin
                cnt_nxt = cnt + 1'b1;
            end else if (!dir_down) begin
                if (cnt == MAX) begin
                    cnt_nxt = MAX - 1'b1;
                    dir_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else begin
                if (cnt == W'(1)) begin
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                    dir_nxt = 1'b1;
                end
            end
        end
    end

    // The cnt=0 sample already compares against the duty being applied at this edge.
    always_comb begin
        raw = '0;
        for (int i = 0; i < CH; i++) begin
            if (apply) begin
                duty_eff[i] = duty_load ? duty_in[i*W +: W] : duty_stg[i];
            end else begin
                duty_eff[i] = duty_act[i];
            end
            raw[i] = (cnt < duty_eff[i]);
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            cnt          <= '0;
            dir_down     <= 1'b0;
            mode_act     <= 1'b0;
            pending      <= 1'b0;
            period_start <= 1'b0;
            pwm_out      <= '0;
            for (int i = 0; i < CH; i++) begin
                duty_stg[i] <= '0;
                duty_act[i] <= '0;
            end
        end else begin
            cnt          <= cnt_nxt;
            dir_down     <= dir_nxt;
            period_start <= apply;
            pwm_out      <= ena ? (raw ^ polarity) : '0;
            if (apply) begin
                mode_act <= center_mode;
                pending  <= 1'b0;
                for (int i = 0; i < CH; i++) begin
                    duty_act[i] <= duty_eff[i];
                end
            end else if (duty_load) begin
                pending <= 1'b1;
            end
            if (duty_load) begin
                for (int i = 0; i < CH; i++) begin
                    duty_stg[i] <= duty_in[i*W +: W];
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_mc.sv
// Testbench for pwm_mc: directed scenarios followed by random traffic, each output sample
// compared against a period-position model of the generator.
module tb_pwm_mc;

    localparam int CH  = 2;
    localparam int W   = 8;
    localparam int MAX = 255;

    logic            clk = 1'b0;
    logic            resetb;
    logic            ena;
    logic            center_mode;
    logic [CH-1:0]   polarity;
    logic [CH*W-1:0] duty_in;
    logic            duty_load;
    logic            pending;
    logic            period_start;
    logic [CH-1:0]   pwm_out;

    always #5 clk = ~clk;

    pwm_mc #(.CH(CH), .W(W)) dut (
        .clk          (clk),
        .resetb       (resetb),
        .ena          (ena),
        .center_mode  (center_mode),
        .polarity     (polarity),
        .duty_in      (duty_in),
        .duty_load    (duty_load),
        .pending      (pending),
        .period_start (period_start),
        .pwm_out      (pwm_out)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model state: position within the current period plus the architectural registers.
    int m_t;
    int m_stg [CH];
    int m_act [CH];
    bit m_center;
    bit m_pend;
    int hi_n [CH];
    int ps_n;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int cnt_of(input int t, input bit center);
        if (center && t > MAX) return 2*MAX - t;
        return t;
    endfunction

    function automatic int pick_duty();
        case ($urandom_range(0, 4))
            0:       return 0;
            1:       return 1;
            2:       return MAX;
            3:       return MAX - 1;
            default: return int'($urandom_range(0, MAX));
        endcase
    endfunction

    task automatic model_reset();
        m_t      = 0;
        m_center = 1'b0;
        m_pend   = 1'b0;
        for (int i = 0; i < CH; i++) begin
            m_stg[i] = 0;
            m_act[i] = 0;
        end
    endtask

    task automatic clear_acc();
        ps_n = 0;
        for (int i = 0; i < CH; i++) hi_n[i] = 0;
    endtask

    task automatic load(input int d0, input int d1);
        duty_in   = {d1[W-1:0], d0[W-1:0]};
        duty_load = 1'b1;
    endtask

    // One clock: predict, advance the model, then compare the registered outputs.
    task automatic apply_stimulus();
        bit            apply;
        int            eff [CH];
        int            c;
        logic [CH-1:0] exp_pwm;
        apply = ena && (m_t == 0);
        c = cnt_of(m_t, m_center);
        for (int i = 0; i < CH; i++) begin
            if (apply) eff[i] = duty_load ? int'(duty_in[i*W +: W]) : m_stg[i];
            else       eff[i] = m_act[i];
            exp_pwm[i] = ena & ((c < eff[i]) ^ polarity[i]);
        end
        if (apply) begin
            m_center = center_mode;
            m_pend   = 1'b0;
            for (int i = 0; i < CH; i++) m_act[i] = eff[i];
        end
        if (duty_load) begin
            for (int i = 0; i < CH; i++) m_stg[i] = int'(duty_in[i*W +: W]);
            if (!apply) m_pend = 1'b1;
        end
        if (!ena) m_t = 0;
        else      m_t = (m_t + 1) % (m_center ? 2*MAX : MAX + 1);
        @(posedge clk);
        #1;
        duty_load = 1'b0;
        check_output("pwm_out", 32'(pwm_out), 32'(exp_pwm));
        check_output("period_start", 32'(period_start), 32'(apply));
        check_output("pending", 32'(pending), 32'(m_pend));
        for (int i = 0; i < CH; i++) if (pwm_out[i]) hi_n[i]++;
        if (period_start) ps_n++;
    endtask

    task automatic run_to(input int target);
        int n = 0;
        while (m_t != target && n < 4000) begin
            apply_stimulus();
            n++;
        end
        if (m_t != target) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL run_to: observed position %0d expected %0d", m_t, target);
        end
    endtask

    initial begin
        resetb      = 1'b0;
        ena         = 1'b0;
        center_mode = 1'b0;
        polarity    = '0;
        duty_in     = '0;
        duty_load   = 1'b0;
        model_reset();
        clear_acc();
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_pwm", 32'(pwm_out), 32'd0);
        check_output("reset_ps", 32'(period_start), 32'd0);
        check_output("reset_pending", 32'(pending), 32'd0);
        resetb = 1'b1;

        // Edge mode, ch0 = 0x80, ch1 = 0x00, loaded while disabled.
        load(8'h80, 8'h00);
        apply_stimulus();
        ena = 1'b1;
        clear_acc();
        repeat (256) apply_stimulus();
        check_output("edge_hi0", 32'(hi_n[0]), 32'd128);
        check_output("edge_hi1", 32'(hi_n[1]), 32'd0);
        check_output("edge_ps", 32'(ps_n), 32'd1);

        // Asynchronous reset in the middle of a period with a load pending.
        run_to(90);
        load(8'h20, 8'h20);
        apply_stimulus();
        run_to(100);
        #1 resetb = 1'b0;
        #1;
        check_output("midrst_pwm", 32'(pwm_out), 32'd0);
        check_output("midrst_ps", 32'(period_start), 32'd0);
        check_output("midrst_pending", 32'(pending), 32'd0);
        model_reset();
        repeat (3) @(posedge clk);
        #2 resetb = 1'b1;
        clear_acc();
        apply_stimulus();
        check_output("rst_first_ps", 32'(ps_n), 32'd1);

        // Edge mode with ch0 inverted.
        polarity = 2'b01;
        load(8'h40, 8'hFF);
        apply_stimulus();
        run_to(0);
        clear_acc();
        repeat (256) apply_stimulus();
        check_output("pol_hi0", 32'(hi_n[0]), 32'd192);
        check_output("pol_hi1", 32'(hi_n[1]), 32'd255);
        check_output("pol_ps", 32'(ps_n), 32'd1);

        // Center mode.
        polarity    = 2'b00;
        center_mode = 1'b1;
        load(8'h80, 8'h01);
        apply_stimulus();
        run_to(0);
        clear_acc();
        repeat (510) apply_stimulus();
        check_output("ctr_hi0", 32'(hi_n[0]), 32'd255);
        check_output("ctr_hi1", 32'(hi_n[1]), 32'd1);
        check_output("ctr_ps", 32'(ps_n), 32'd1);
        apply_stimulus();
        check_output("ctr_period", 32'(ps_n), 32'd2);

        // Double buffering in edge mode.
        center_mode = 1'b0;
        load(8'h80, 8'h80);
        apply_stimulus();
        run_to(0);
        apply_stimulus();
        run_to(100);
        load(8'h20, 8'h20);
        apply_stimulus();
        run_to(0);
        clear_acc();
        repeat (256) apply_stimulus();
        check_output("dbuf_hi0", 32'(hi_n[0]), 32'd32);
        load(8'h10, 8'h10);
        clear_acc();
        repeat (256) apply_stimulus();
        check_output("applyload_hi0", 32'(hi_n[0]), 32'd16);

        // Disable mid-period and switch to center mode while disabled.
        run_to(50);
        ena = 1'b0;
        apply_stimulus();
        center_mode = 1'b1;
        repeat (5) apply_stimulus();
        ena = 1'b1;
        clear_acc();
        repeat (510) apply_stimulus();
        check_output("reen_ps", 32'(ps_n), 32'd1);
        check_output("reen_hi0", 32'(hi_n[0]), 32'd31);
        apply_stimulus();
        check_output("reen_period", 32'(ps_n), 32'd2);

        // Random traffic.
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 29) == 0) load(pick_duty(), pick_duty());
            if ($urandom_range(0, 499) == 0) polarity = CH'($urandom);
            if ($urandom_range(0, 399) == 0) ena = !ena;
            if ($urandom_range(0, 599) == 0) center_mode = !center_mode;
            apply_stimulus();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
